// File: rtl/nc_icache_multibuffer_if.sv
// rtl/nc_icache_multibuffer_if.sv - L2 line-fill request/grant bus of the non-cacheable fetch buffer
interface nc_icache_multibuffer_if #(
   parameter int PADDR_W    = 40,
   parameter int LINE_BYTES = 8
);
   logic                    req_nc_valid_o;
   logic [PADDR_W-1:0]      req_nc_paddr_o;
   logic                    req_nc_ready_i;
   logic                    l2_grant_valid_i;
   logic [LINE_BYTES*8-1:0] l2_resp_data_i;

   modport master (
      output req_nc_valid_o, req_nc_paddr_o,
      input  req_nc_ready_i, l2_grant_valid_i, l2_resp_data_i
   );

   modport slave (
      input  req_nc_valid_o, req_nc_paddr_o,
      output req_nc_ready_i, l2_grant_valid_i, l2_resp_data_i
   );
endinterface

// File: rtl/nc_icache_multibuffer.sv
// rtl/nc_icache_multibuffer.sv - N-line fully-associative non-cacheable instruction fetch buffer
module nc_icache_multibuffer #(
   parameter int NUM_ENTRIES = 4,
   parameter int LINE_BYTES  = 8,
   parameter int PADDR_W     = 40,
   parameter int INSTR_W     = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    en_translation_i,
   input  logic                    req_valid_i,
   input  logic [PADDR_W-1:0]      req_vaddr_i,
   input  logic                    req_is_nc_i,
   input  logic                    req_kill_i,
   input  logic                    req_flush_i,
   input  logic                    req_icache_ready_i,
   output logic                    req_icache_ready_o,
   output logic                    req_icache_valid_o,
   nc_icache_multibuffer_if.master l2_if,
   output logic                    nc_resp_valid_o,
   output logic [INSTR_W-1:0]      nc_resp_data_o
);
   localparam int OFF    = $clog2(LINE_BYTES);
   localparam int TAG_W  = PADDR_W - OFF;
   localparam int LINE_W = LINE_BYTES * 8;
   localparam int WIDX_W = OFF - 2;
   localparam int IDX_W  = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_KILL = 2'd3;

   logic [1:0]             state_q, state_d;
   logic                   s2_valid_q;
   logic [PADDR_W-1:0]     s2_vaddr_q;
   logic                   resp_pend_q;
   logic [INSTR_W-1:0]     resp_word_q;
   logic [NUM_ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]       tag_q  [NUM_ENTRIES];
   logic [LINE_W-1:0]      line_q [NUM_ENTRIES];
   logic [IDX_W-1:0]       rr_q;

   logic                   nc_req_d;
   logic [TAG_W-1:0]       s2_tag;
   logic [WIDX_W-1:0]      s2_widx;
   logic                   hit, s2_hit, s2_miss;
   logic [IDX_W-1:0]       hit_idx;
   logic [IDX_W-1:0]       victim;
   logic                   have_free;
   logic                   grant_fill, do_fill;

   function automatic logic [INSTR_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                   input logic [WIDX_W-1:0] w);
      return line[w*INSTR_W +: INSTR_W];
   endfunction

   assign s2_tag  = s2_vaddr_q[PADDR_W-1:OFF];
   assign s2_widx = s2_vaddr_q[OFF-1:2];

   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (valid_q[i] && tag_q[i] == s2_tag) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   // Descending scan so the lowest-index free entry wins; fall back to round-robin.
   always_comb begin
      victim    = rr_q;
      have_free = 1'b0;
      for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            victim    = IDX_W'(i);
            have_free = 1'b1;
         end
      end
   end

   assign s2_hit  = s2_valid_q & hit;
   assign s2_miss = s2_valid_q & ~hit;

   assign req_icache_valid_o = req_valid_i & ~(req_is_nc_i & ~en_translation_i);
   assign req_icache_ready_o = req_icache_ready_i & (state_q == S_IDLE) & ~s2_miss;
   assign nc_req_d = req_valid_i & req_is_nc_i & ~en_translation_i & ~req_kill_i & req_icache_ready_o;

   assign grant_fill = (state_q == S_WAIT) & l2_if.l2_grant_valid_i;
   assign do_fill    = grant_fill & ~req_flush_i;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (s2_miss) state_d = S_REQ;
         S_REQ: begin
            if (req_kill_i)                state_d = S_IDLE;
            else if (l2_if.req_nc_ready_i) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (l2_if.l2_grant_valid_i) state_d = S_IDLE;
            else if (req_kill_i)        state_d = S_KILL;
         end
         S_KILL: if (l2_if.l2_grant_valid_i) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         s2_valid_q  <= 1'b0;
         resp_pend_q <= 1'b0;
         valid_q     <= '0;
         rr_q        <= '0;
      end else begin
         state_q     <= state_d;
         s2_valid_q  <= nc_req_d;
         resp_pend_q <= grant_fill;
         if (req_flush_i) begin
            valid_q <= '0;
         end else if (do_fill) begin
            valid_q[victim] <= 1'b1;
         end
         if (do_fill && !have_free) begin
            rr_q <= (rr_q == IDX_W'(NUM_ENTRIES - 1)) ? '0 : rr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (nc_req_d) s2_vaddr_q <= req_vaddr_i;
      if (grant_fill) resp_word_q <= sel_word(l2_if.l2_resp_data_i, s2_widx);
      if (do_fill) begin
         tag_q[victim]  <= s2_tag;
         line_q[victim] <= l2_if.l2_resp_data_i;
      end
   end

   assign l2_if.req_nc_valid_o = (state_q == S_REQ);
   assign l2_if.req_nc_paddr_o = (state_q == S_REQ) ? {s2_tag, {OFF{1'b0}}} : '0;

   assign nc_resp_valid_o = s2_hit | resp_pend_q;
   assign nc_resp_data_o  = resp_pend_q ? resp_word_q :
                            s2_hit      ? sel_word(line_q[hit_idx], s2_widx) : '0;
endmodule

// File: tb/tb_nc_icache_multibuffer.sv
// tb/tb_nc_icache_multibuffer.sv - directed plus randomized bench with a line-buffer reference model
module tb_nc_icache_multibuffer;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst, en_tr, req_valid, is_nc, kill, flush, icr_i;
   logic [39:0] vaddr;
   logic        icr_o, icv_o, resp_valid;
   logic [31:0] resp_data;

   nc_icache_multibuffer_if #(.PADDR_W(40), .LINE_BYTES(8)) l2 ();

   nc_icache_multibuffer #(.NUM_ENTRIES(N), .LINE_BYTES(8), .PADDR_W(40), .INSTR_W(32)) dut (
      .clk_i(clk), .rst_i(rst), .en_translation_i(en_tr), .req_valid_i(req_valid),
      .req_vaddr_i(vaddr), .req_is_nc_i(is_nc), .req_kill_i(kill), .req_flush_i(flush),
      .req_icache_ready_i(icr_i), .req_icache_ready_o(icr_o), .req_icache_valid_o(icv_o),
      .l2_if(l2), .nc_resp_valid_o(resp_valid), .nc_resp_data_o(resp_data)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference: N line slots, a backing memory keyed by line address, round-robin pointer.
   bit          m_val [N];
   logic [36:0] m_tag [N];
   int          m_rr;
   logic [63:0] mem [logic [36:0]];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] get_line(input logic [36:0] t);
      if (!mem.exists(t)) mem[t] = {$urandom, $urandom};
      return mem[t];
   endfunction

   function automatic bit model_hit(input logic [36:0] t);
      for (int i = 0; i < N; i++) if (m_val[i] && m_tag[i] == t) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_fill(input logic [36:0] t);
      int v;
      v = -1;
      for (int i = 0; i < N; i++) if (!m_val[i] && v < 0) v = i;
      if (v < 0) begin
         v = m_rr;
         m_rr = (m_rr + 1) % N;
      end
      m_val[v] = 1'b1;
      m_tag[v] = t;
   endtask

   task automatic model_clear(input bit reset_rr);
      for (int i = 0; i < N; i++) m_val[i] = 1'b0;
      if (reset_rr) m_rr = 0;
   endtask

   // mode: 0 normal, 1 kill in WAIT, 2 kill in REQ, 3 flush with grant, 4 reset in WAIT
   task automatic fetch(input logic [39:0] a, input int mode, input int rdly, input int gdly);
      logic [36:0] t;
      logic [63:0] line;
      logic [31:0] word;
      t = a[39:3];
      req_valid = 1'b1; vaddr = a; is_nc = 1'b1; en_tr = 1'b0;
      #1;
      chk("nc_not_to_icache", icv_o, 0);
      chk("ready_at_capture", icr_o, 1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      line = get_line(t);
      word = a[2] ? line[63:32] : line[31:0];
      if (model_hit(t)) begin
         chk("hit_valid", resp_valid, 1);
         chk("hit_data", resp_data, word);
         chk("hit_no_l2", l2.req_nc_valid_o, 0);
         return;
      end
      chk("miss_no_resp", resp_valid, 0);
      chk("miss_stall", icr_o, 0);
      @(negedge clk); #1;
      chk("l2_req_valid", l2.req_nc_valid_o, 1);
      chk("l2_req_paddr", l2.req_nc_paddr_o, {t, 3'b000});
      if (mode == 2) begin
         kill = 1'b1; l2.req_nc_ready_i = 1'b1;
         @(negedge clk);
         kill = 1'b0; l2.req_nc_ready_i = 1'b0;
         #1;
         chk("kill_req_drop", l2.req_nc_valid_o, 0);
         chk("kill_req_idle", icr_o, 1);
         return;
      end
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk); #1;
         chk("hold_valid", l2.req_nc_valid_o, 1);
         chk("hold_paddr", l2.req_nc_paddr_o, {t, 3'b000});
         chk("hold_stall", icr_o, 0);
      end
      l2.req_nc_ready_i = 1'b1;
      @(negedge clk);
      l2.req_nc_ready_i = 1'b0;
      #1;
      chk("wait_no_req", l2.req_nc_valid_o, 0);
      if (mode == 1) begin
         kill = 1'b1;
         @(negedge clk);
         kill = 1'b0;
      end
      if (mode == 4) begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         model_clear(1'b1);
      end
      for (int i = 0; i < gdly; i++) begin
         @(negedge clk); #1;
         chk("wait_no_resp", resp_valid, 0);
      end
      l2.l2_grant_valid_i = 1'b1; l2.l2_resp_data_i = line; flush = (mode == 3);
      @(negedge clk);
      l2.l2_grant_valid_i = 1'b0; l2.l2_resp_data_i = {$urandom, $urandom}; flush = 1'b0;
      #1;
      if (mode == 1 || mode == 4) begin
         chk("dropped_grant_no_resp", resp_valid, 0);
         chk("dropped_grant_no_req", l2.req_nc_valid_o, 0);
      end else begin
         chk("fill_resp_valid", resp_valid, 1);
         chk("fill_resp_data", resp_data, word);
         if (mode == 3) model_clear(1'b0);
         else model_fill(t);
      end
      chk("idle_after_grant", icr_o, 1);
   endtask

   task automatic cache_fetch(input logic [39:0] a);
      bit tr;
      tr = 1'($urandom_range(0, 1));
      req_valid = 1'b1; vaddr = a; en_tr = tr; is_nc = tr;
      #1;
      chk("cacheable_fwd", icv_o, 1);
      @(negedge clk);
      req_valid = 1'b0; en_tr = 1'b0; is_nc = 1'b0;
      #1;
      chk("cacheable_no_resp", resp_valid, 0);
      chk("cacheable_no_l2", l2.req_nc_valid_o, 0);
   endtask

   task automatic killed_fetch(input logic [39:0] a);
      req_valid = 1'b1; vaddr = a; is_nc = 1'b1; kill = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; kill = 1'b0;
      #1;
      chk("killed_no_resp", resp_valid, 0);
      chk("killed_no_stall", icr_o, 1);
   endtask

   initial begin
      rst = 1'b1; en_tr = 1'b0; req_valid = 1'b0; is_nc = 1'b0; kill = 1'b0; flush = 1'b0;
      icr_i = 1'b0; vaddr = '0;
      l2.req_nc_ready_i = 1'b0; l2.l2_grant_valid_i = 1'b0; l2.l2_resp_data_i = '0;
      model_clear(1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", icr_o, 0);
      chk("rst_icache_valid", icv_o, 0);
      chk("rst_l2_valid", l2.req_nc_valid_o, 0);
      chk("rst_l2_paddr", l2.req_nc_paddr_o, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      icr_i = 1'b1;
      @(negedge clk);

      mem[37'h20] = 64'hBBBB_BBBB_AAAA_AAAA;
      fetch(40'h100, 0, 0, 0);
      fetch(40'h104, 0, 0, 0);
      chk("cold_hit_word", resp_data, 32'hBBBB_BBBB);
      fetch(40'h200, 0, 0, 1);
      fetch(40'h300, 0, 1, 0);
      fetch(40'h400, 0, 0, 0);
      fetch(40'h500, 0, 0, 0);
      fetch(40'h100, 0, 0, 0);
      fetch(40'h700, 0, 5, 2);
      fetch(40'h600, 1, 1, 1);
      fetch(40'h600, 0, 0, 0);
      fetch(40'h800, 2, 0, 0);
      fetch(40'h800, 0, 0, 0);
      fetch(40'h900, 3, 0, 1);
      fetch(40'h900, 0, 0, 0);
      fetch(40'hA00, 4, 0, 0);
      fetch(40'hA04, 0, 0, 0);
      killed_fetch(40'hA04);
      cache_fetch(40'hA04);
      fetch(40'hA00, 0, 0, 0);

      for (int k = 0; k < 80; k++) begin
         int r, m;
         logic [39:0] a;
         a = 40'h2000 + 40'($urandom_range(0, 7)) * 8 + 40'($urandom_range(0, 1)) * 4;
         r = $urandom_range(0, 19);
         if (r < 14) begin
            m = $urandom_range(0, 9);
            fetch(a, (m < 7) ? 0 : m - 6, $urandom_range(0, 3), $urandom_range(0, 3));
         end else if (r < 16) begin
            cache_fetch(a);
         end else if (r < 18) begin
            killed_fetch(a);
         end else if (r < 19) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
            model_clear(1'b0);
         end else begin
            fetch(a, 4, $urandom_range(0, 2), $urandom_range(0, 2));
         end
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
